// File: rtl/bram_dual.sv
// bram_dual: simple dual-port RAM with registered read and write-through on address match
module bram_dual #(
    parameter int memSize_p   = 8,
    parameter int dataWidth_p = 16
) (
    input  logic                   clk_i,
    input  logic                   write_i,
    input  logic [memSize_p-1:0]   waddr_i,
    input  logic [dataWidth_p-1:0] data_i,
    input  logic [memSize_p-1:0]   raddr_i,
    output logic [dataWidth_p-1:0] data_o
);
    logic [dataWidth_p-1:0] mem_q [2**memSize_p];
    // write port and one-cycle-latency read port; a same-address write is forwarded to the read data
    always_ff @(posedge clk_i) begin
        if (write_i) mem_q[waddr_i] <= data_i;
        data_o <= (write_i && waddr_i == raddr_i) ? data_i : mem_q[raddr_i];
    end
endmodule

// File: rtl/bram_fifo.sv
// bram_fifo: first-word-fall-through FIFO over bram_dual with a two-entry output buffer hiding RAM read latency
module bram_fifo #(
    parameter int memSize_p   = 8,
    parameter int dataWidth_p = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [dataWidth_p-1:0] data_i,
    output logic                   full_o,
    output logic                   overflow_o,
    output logic [dataWidth_p-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [memSize_p:0]     level_o
);
    localparam logic [memSize_p:0] DEPTH = {1'b1, {memSize_p{1'b0}}};
    localparam logic [memSize_p:0] ONE   = {{memSize_p{1'b0}}, 1'b1};
    logic [memSize_p:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d, stored;
    logic [1:0]             oc_q, oc_d;
    logic                   pend_q, hd_q, hd_d, tl_q, tl_d, full_q, full_d, ovf_q, ovf_d;
    logic                   push_ok, pop, fetch;
    logic [dataWidth_p-1:0] buf_q [2];
    logic [dataWidth_p-1:0] ram_rd;

    bram_dual #(.memSize_p(memSize_p), .dataWidth_p(dataWidth_p)) u_ram (
        .clk_i  (clk_i),
        .write_i(push_ok),
        .waddr_i(wr_ptr_q[memSize_p-1:0]),
        .data_i (data_i),
        .raddr_i(rd_ptr_q[memSize_p-1:0]),
        .data_o (ram_rd)
    );

    // fetch only while the buffer plus the word in flight cannot exceed two entries after this cycle's pop
    always_comb begin
        push_ok  = push_i && !full_q;
        pop      = (oc_q != 2'd0) && ready_i;
        stored   = wr_ptr_q - rd_ptr_q;
        fetch    = (stored != '0) && (({1'b0, oc_q} + {2'b0, pend_q} - {2'b0, pop}) < 3'd2);
        wr_ptr_d = push_ok ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d = fetch ? rd_ptr_q + ONE : rd_ptr_q;
        level_d  = level_q + (push_ok ? ONE : '0) - (pop ? ONE : '0);
        full_d   = level_d == DEPTH;
        ovf_d    = push_i && full_q;
        oc_d     = oc_q + {1'b0, pend_q} - {1'b0, pop};
        hd_d     = hd_q ^ pop;
        tl_d     = tl_q ^ pend_q;
    end

    // pointers, counters and the output buffer; a pending fetch lands at the buffer tail
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            oc_q      <= 2'd0;
            pend_q    <= 1'b0;
            hd_q      <= 1'b0;
            tl_q      <= 1'b0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            oc_q      <= oc_d;
            pend_q    <= fetch;
            hd_q      <= hd_d;
            tl_q      <= tl_d;
            if (pend_q) buf_q[tl_q] <= ram_rd;
        end
    end

    assign data_o     = buf_q[hd_q];
    assign valid_o    = oc_q != 2'd0;
    assign level_o    = level_q;
    assign full_o     = full_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_bram_fifo.sv
// tb_bram_fifo: randomized and directed checks of bram_fifo against a queue-based reference model
module tb_bram_fifo;
    localparam int MS = 8;
    localparam int DW = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0, rst = 1'b1, push_i = 1'b0, ready_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          full_o, overflow_o, valid_o;
    logic [DW-1:0] data_o;
    logic [MS:0]   level_o;

    bram_fifo #(.memSize_p(MS), .dataWidth_p(DW)) dut (
        .clk_i(clk), .rst_i(rst), .push_i(push_i), .data_i(data_i),
        .full_o(full_o), .overflow_o(overflow_o), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .level_o(level_o)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: accepted words with the edge index at which they were accepted
    typedef struct { logic [DW-1:0] d; int t; } ent_t;
    ent_t          q[$];
    int            edge_n = 0;
    logic          ovf_m = 1'b0, hold_m = 1'b0;
    logic [DW-1:0] hold_d = '0;

    // a word becomes visible two edges after the edge that accepted it
    function automatic logic mvalid();
        return q.size() > 0 && q[0].t <= edge_n - 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            ovf_m = 1'b0;
            hold_m = 1'b0;
        end else begin
            int sz;
            logic mv;
            sz = q.size();
            mv = mvalid();
            hold_m = mv && !ready_i;
            if (mv) hold_d = q[0].d;
            edge_n++;
            if (mv && ready_i) void'(q.pop_front());
            if (push_i && sz != DEPTH) q.push_back('{data_i, edge_n});
            ovf_m = push_i && sz == DEPTH;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("level", 32'(level_o), 32'(q.size()));
            chk("full", 32'(full_o), 32'(q.size() == DEPTH));
            chk("overflow", 32'(overflow_o), 32'(ovf_m));
            chk("valid", 32'(valid_o), 32'(mvalid()));
            if (mvalid()) chk("data", 32'(data_o), 32'(q[0].d));
            if (hold_m) begin
                chk("hold_valid", 32'(valid_o), 32'd1);
                chk("hold_data", 32'(data_o), 32'(hold_d));
            end
        end
    end

    task automatic step(input logic p, input logic [DW-1:0] d, input logic r);
        push_i = p;
        data_i = d;
        ready_i = r;
        @(negedge clk);
    endtask

    initial begin
        int bubbles, maxlvl;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        rst = 1'b0;
        // latency
        step(1'b1, 16'hA5A5, 1'b1);
        chk("lat_e0_level", 32'(level_o), 32'd1);
        chk("lat_e0_valid", 32'(valid_o), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("lat_e1_valid", 32'(valid_o), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("lat_e2_valid", 32'(valid_o), 32'd1);
        chk("lat_e2_data", 32'(data_o), 32'hA5A5);
        chk("lat_e2_level", 32'(level_o), 32'd1);
        step(1'b0, '0, 1'b1);
        chk("lat_e3_level", 32'(level_o), 32'd0);
        chk("lat_e3_valid", 32'(valid_o), 32'd0);
        // fill, overflow and full boundary
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_level", 32'(level_o), 32'd256);
        step(1'b1, 16'h1234, 1'b0);
        chk("ovf_pulse", 32'(overflow_o), 32'd1);
        chk("ovf_level", 32'(level_o), 32'd256);
        step(1'b0, '0, 1'b0);
        chk("ovf_clear", 32'(overflow_o), 32'd0);
        step(1'b1, 16'hBEEF, 1'b1);
        chk("bnd_level", 32'(level_o), 32'd255);
        chk("bnd_ovf", 32'(overflow_o), 32'd1);
        chk("bnd_full", 32'(full_o), 32'd0);
        for (int e = 1; e < DEPTH; e++) begin
            chk("drain_valid", 32'(valid_o), 32'd1);
            chk("drain_data", 32'(data_o), 32'(e));
            step(1'b0, '0, 1'b1);
        end
        chk("drain_level", 32'(level_o), 32'd0);
        chk("drain_valid_end", 32'(valid_o), 32'd0);
        // streaming
        bubbles = 0;
        maxlvl = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, DW'(i + 7), 1'b1);
            if (i >= 2 && !valid_o) bubbles++;
            if (int'(level_o) > maxlvl) maxlvl = int'(level_o);
        end
        chk("stream_bubbles", 32'(bubbles), 32'd0);
        chk("stream_maxlvl_le3", 32'(maxlvl <= 3), 32'd1);
        repeat (6) step(1'b0, '0, 1'b1);
        chk("stream_level", 32'(level_o), 32'd0);
        // random backpressure
        repeat (5000) step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
        repeat (300) step(1'b0, '0, 1'b1);
        chk("rand_level", 32'(level_o), 32'd0);
        // mid-stream reset with words stored and a fetch in flight
        for (int i = 0; i < 11; i++) step(1'b1, DW'(16'h300 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        chk("mr_level", 32'(level_o), 32'd10);
        #2 rst = 1'b1;
        #1;
        chk("mr_valid", 32'(valid_o), 32'd0);
        chk("mr_data", 32'(data_o), 32'd0);
        chk("mr_level0", 32'(level_o), 32'd0);
        chk("mr_full", 32'(full_o), 32'd0);
        chk("mr_ovf", 32'(overflow_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 16'h0042, 1'b1);
        chk("mr_e0_valid", 32'(valid_o), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("mr_e1_valid", 32'(valid_o), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("mr_e2_valid", 32'(valid_o), 32'd1);
        chk("mr_e2_data", 32'(data_o), 32'h0042);
        step(1'b0, '0, 1'b1);
        chk("mr_e3_valid", 32'(valid_o), 32'd0);
        repeat (5) step(1'b0, '0, 1'b1);
        chk("mr_no_stale", 32'(valid_o), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
